tt_um_tomamints_sum_seq: RTL and testbench

//  Sequencing controller for the shared 8-bit operand adder: accumulates a stream of bytes into an ACC_W-bit sum.

---
 rtl/tt_um_tomamints_sum_seq.sv | 108 ++++++++++
 tb/tb_tt_um_tomamints_sum_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_tomamints_sum_seq.sv
// Byte-stream accumulator tile: synchronises slow host strobes, detects rising edges,
// and sequences an ACC_W-bit wrapping sum with busy/done/overflow/error status.
module tt_um_tomamints_sum_seq #(
    parameter int ACC_W       = 12,
    parameter int MAX_OPS     = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OPS);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic [3:0]         sync_q [SYNC_STAGES];
    logic [3:0]         synced;
    logic [1:0]         prev_q;
    logic               start_rise;
    logic               valid_rise;
    logic [ACC_W:0]     sum;
    logic [11:0]        acc_ext;
    logic               unused_pins;

    assign unused_pins = &{1'b0, uio_in[7:4]};

    assign synced     = sync_q[SYNC_STAGES-1];
    assign start_rise = synced[0] & ~prev_q[0];
    assign valid_rise = synced[1] & ~prev_q[1];

    // Synchroniser and edge history run regardless of ena so a rise seen while
    // disabled is consumed rather than replayed when the tile is re-enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= uio_in[3:0];
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= synced[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign sum = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, ui_in};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (ena) begin
            if (start_rise) begin
                // A coincident valid rise is deliberately dropped here.
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                err_d   = 1'b0;
                state_d = ACCUM;
            end else if (valid_rise) begin
                case (state_q)
                    ACCUM: begin
                        acc_d = sum[ACC_W-1:0];
                        cnt_d = cnt_q + 4'd1;
                        if (sum[ACC_W]) ovf_d = 1'b1;
                        if (synced[2] || (cnt_d == MAX_CNT)) state_d = DONE;
                    end
                    DONE:    err_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign acc_ext = 12'(acc_q);
    assign uo_out  = synced[3] ? {cnt_q, acc_ext[11:8]} : acc_q[7:0];
    assign uio_out = {err_q, ovf_q, state_q == DONE, state_q == ACCUM, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_tomamints_sum_seq.sv
// Scoreboard bench: two tile instances (default and a narrow/short/deep-sync variant)
// driven in parallel and compared against a plain arithmetic model of the sum sequence.
module tb_tt_um_tomamints_sum_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic       start_pin, valid_pin, last_pin, hi_pin;
    logic [3:0] junk;
    logic [7:0] uio_in;
    logic [7:0] uio_out_a, uio_oe_a, uo_out_a;
    logic [7:0] uio_out_b, uio_oe_b, uo_out_b;

    assign uio_in = {junk, hi_pin, last_pin, valid_pin, start_pin};

    always #5 clk = ~clk;

    tt_um_tomamints_sum_seq dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uio_out(uio_out_a), .uio_oe(uio_oe_a), .uo_out(uo_out_a)
    );

    tt_um_tomamints_sum_seq #(.ACC_W(9), .MAX_OPS(4), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uio_out(uio_out_b), .uio_oe(uio_oe_b), .uo_out(uo_out_b)
    );

    // Reference model: phase 0=idle 1=accumulating 2=done; total is the unwrapped sum.
    int    aw [2] = '{12, 9};
    int    mo [2] = '{15, 4};
    int    phase [2];
    longint total [2];
    int    cnt [2];
    bit    err [2];
    bit    hs;

    typedef struct {
        logic [7:0] uo_a, uio_a, uo_b, uio_b;
        string      tag;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;

    task automatic compare(input string nm, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %02h expected %02h", nm, act, want);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            compare({mon_e.tag, " uo_out[a]"},  uo_out_a,  mon_e.uo_a);
            compare({mon_e.tag, " uio_out[a]"}, uio_out_a, mon_e.uio_a);
            compare({mon_e.tag, " uo_out[b]"},  uo_out_b,  mon_e.uo_b);
            compare({mon_e.tag, " uio_out[b]"}, uio_out_b, mon_e.uio_b);
            compare({mon_e.tag, " uio_oe"},     uio_oe_a & uio_oe_b, 8'hF0);
        end
    end

    function automatic logic [7:0] model_uo(input int k);
        longint     acc;
        logic [3:0] c;
        logic [3:0] h;
        acc = total[k] & ((longint'(1) << aw[k]) - 1);
        c   = cnt[k][3:0];
        h   = 4'((acc >> 8) & 15);
        return hs ? {c, h} : 8'(acc & 255);
    endfunction

    function automatic logic [7:0] model_uio(input int k);
        logic ovf;
        ovf = (total[k] >= (longint'(1) << aw[k]));
        return {err[k], ovf, phase[k] == 2, phase[k] == 1, 4'b0000};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            phase[k] = 0; total[k] = 0; cnt[k] = 0; err[k] = 1'b0;
        end
    endtask

    task automatic model_apply(input bit s, input bit v, input logic [7:0] d, input bit l);
        if (!ena) return;
        for (int k = 0; k < 2; k++) begin
            if (s) begin
                phase[k] = 1; total[k] = 0; cnt[k] = 0; err[k] = 1'b0;
            end else if (v) begin
                if (phase[k] == 1) begin
                    total[k] += d;
                    cnt[k]++;
                    if (l || cnt[k] == mo[k]) phase[k] = 2;
                end else if (phase[k] == 2) begin
                    err[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string tag);
        exp_t e;
        e.uo_a  = model_uo(0);
        e.uio_a = model_uio(0);
        e.uo_b  = model_uo(1);
        e.uio_b = model_uio(1);
        e.tag   = tag;
        exp_q.push_back(e);
        cyc(1);
    endtask

    task automatic set_hi(input bit h);
        hi_pin = h;
        hs     = h;
        junk   = 4'($urandom);
        cyc(5);
    endtask

    task automatic check_views(input string tag);
        set_hi(1'b0);
        expect_now({tag, " lo"});
        set_hi(1'b1);
        expect_now({tag, " hi"});
        set_hi(1'b0);
    endtask

    task automatic pulse(input bit s, input bit v, input logic [7:0] d, input bit l);
        ui_in    = d;
        last_pin = l;
        cyc(1);
        model_apply(s, v, d, l);
        start_pin = s;
        valid_pin = v;
        cyc(6);
        start_pin = 1'b0;
        valid_pin = 1'b0;
        cyc(6);
        last_pin = 1'b0;
        ui_in    = 8'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         l;
        int         r;

        // Reset with random pins
        rst_n = 1'b0;
        ena   = 1'($urandom);
        ui_in = 8'($urandom);
        {hi_pin, last_pin, valid_pin, start_pin} = 4'($urandom);
        junk = 4'($urandom);
        hs = 1'b0;
        model_reset();
        cyc(3);
        expect_now("reset");
        {hi_pin, last_pin, valid_pin, start_pin} = 4'b0000;
        ena = 1'b1;
        cyc(5);
        rst_n = 1'b1;
        cyc(5);
        expect_now("post-reset idle");

        // Valid while idle is ignored
        pulse(1'b0, 1'b1, 8'h55, 1'b0);
        expect_now("idle valid");

        // Basic sum 0x10+0x20+0x05
        pulse(1'b1, 1'b0, 8'h00, 1'b0);
        expect_now("after start");
        pulse(1'b0, 1'b1, 8'h10, 1'b0);
        pulse(1'b0, 1'b1, 8'h20, 1'b0);
        expect_now("mid accum");
        pulse(1'b0, 1'b1, 8'h05, 1'b1);
        check_views("sum35");

        // Wrap: 0xFF+0xFF+0x03
        pulse(1'b1, 1'b0, 8'h00, 1'b0);
        pulse(1'b0, 1'b1, 8'hFF, 1'b0);
        pulse(1'b0, 1'b1, 8'hFF, 1'b0);
        pulse(1'b0, 1'b1, 8'h03, 1'b1);
        check_views("wrap");

        // Forced completion on operand count
        pulse(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 15; i++) pulse(1'b0, 1'b1, 8'h01, 1'b0);
        check_views("max ops");

        // Valid in DONE sets err, then start clears
        pulse(1'b0, 1'b1, 8'h44, 1'b0);
        check_views("done valid");
        pulse(1'b1, 1'b0, 8'h00, 1'b0);
        expect_now("restart");

        // Reset mid-sequence
        pulse(1'b0, 1'b1, 8'h21, 1'b0);
        pulse(1'b0, 1'b1, 8'h42, 1'b0);
        expect_now("before reset");
        rst_n = 1'b0;
        model_reset();
        #2;
        exp_q.push_back('{8'h00, 8'h00, 8'h00, 8'h00, "async reset"});
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        pulse(1'b0, 1'b1, 8'h77, 1'b1);
        expect_now("valid after reset");
        pulse(1'b1, 1'b0, 8'h00, 1'b0);
        expect_now("start after reset");

        // Coincident start and valid: operand dropped
        pulse(1'b0, 1'b1, 8'h09, 1'b0);
        pulse(1'b1, 1'b1, 8'h33, 1'b0);
        check_views("start+valid");

        // Rises while disabled are discarded
        ena = 1'b0;
        cyc(1);
        pulse(1'b0, 1'b1, 8'h66, 1'b0);
        expect_now("ena0 valid");
        ena = 1'b1;
        cyc(6);
        expect_now("ena restored");

        // Randomised traffic
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 11);
            d = 8'($urandom);
            l = ($urandom_range(0, 5) == 0);
            if (r < 2) begin
                pulse(1'b1, 1'b0, d, l);
            end else if (r < 9) begin
                pulse(1'b0, 1'b1, d, l);
            end else if (r == 9) begin
                ena = 1'b0;
                cyc(1);
                pulse($urandom_range(0, 1) == 1, 1'b1, d, l);
                ena = 1'b1;
                cyc(2);
            end else if (r == 10) begin
                pulse(1'b1, 1'b1, d, l);
            end else begin
                check_views("rand views");
            end
            expect_now("rand");
        end

        cyc(3);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
